// File: rtl/writeback_stage_if.sv
// Execute-to-writeback result bus: one retiring instruction per accepted beat.
// The producer holds every field stable while in_valid is high and in_ready is low.
interface writeback_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rd;
    logic            in_rd_we;
    logic [XLEN-1:0] in_rd_value;
    logic            in_redirect;
    logic [XLEN-1:0] in_next_pc;
    logic            in_halt;

    modport master (
        output in_valid, in_pc, in_rd, in_rd_we, in_rd_value,
               in_redirect, in_next_pc, in_halt,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_rd, in_rd_we, in_rd_value,
               in_redirect, in_next_pc, in_halt,
        output in_ready
    );
endinterface

// File: rtl/writeback_stage.sv
// RV32I writeback: register file, committed PC, instret and halt/fault FSM; effects land 1 cycle after accept.
// in_ready is high only in RUN and never depends on in_valid; HALT/FAULT backpressure until reset.
module writeback_stage #(
    parameter int              XLEN     = 32,
    parameter int              NUM_REGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_stage_if.slave  wb,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   pc_out,
    output logic              flush,
    output logic              halted,
    output logic              err_misaligned,
    output logic [63:0]       instret
);
    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];
    logic [XLEN-1:0] pc_q, pc_d;
    logic [63:0]     instret_q, instret_d;
    logic            flush_q, flush_d;
    logic            halted_q, halted_d;
    logic            err_q, err_d;

    logic            accept;
    logic [XLEN-1:0] tgt;
    logic            mis;
    logic            wr_en;
    logic            unused_npc_lsb;

    // JALR semantics: target bit 0 is dropped; bit 1 set means a misaligned fetch.
    assign tgt            = {wb.in_next_pc[XLEN-1:1], 1'b0};
    assign unused_npc_lsb = wb.in_next_pc[0];
    assign mis            = wb.in_redirect & tgt[1];
    assign wb.in_ready    = (state_q == ST_RUN);
    assign accept         = wb.in_valid & wb.in_ready;
    assign wr_en          = accept & ~mis & wb.in_rd_we & (wb.in_rd != 5'd0);

    always_comb begin
        rs1_data = '0;
        if (rs1_addr != 5'd0) begin
            if ((BYPASS != 0) && wr_en && (wb.in_rd == rs1_addr))
                rs1_data = wb.in_rd_value;
            else
                rs1_data = regs_q[rs1_addr];
        end
        rs2_data = '0;
        if (rs2_addr != 5'd0) begin
            if ((BYPASS != 0) && wr_en && (wb.in_rd == rs2_addr))
                rs2_data = wb.in_rd_value;
            else
                rs2_data = regs_q[rs2_addr];
        end
    end

    always_comb begin
        regs_d    = regs_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        flush_d   = 1'b0;
        err_d     = err_q;
        state_d   = state_q;
        if (wr_en)
            regs_d[wb.in_rd] = wb.in_rd_value;
        if (accept) begin
            if (mis) begin
                // Faulting instruction does not retire; PC parks on it for debug.
                pc_d    = wb.in_pc;
                err_d   = 1'b1;
                flush_d = 1'b1;
                state_d = ST_FAULT;
            end else begin
                pc_d      = wb.in_redirect ? tgt : wb.in_pc + XLEN'(4);
                flush_d   = wb.in_redirect;
                instret_d = instret_q + 64'd1;
                if (wb.in_halt)
                    state_d = ST_HALT;
            end
        end
        halted_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            pc_q      <= RESET_PC;
            instret_q <= '0;
            flush_q   <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            state_q   <= ST_RUN;
        end else begin
            regs_q    <= regs_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            flush_q   <= flush_d;
            halted_q  <= halted_d;
            err_q     <= err_d;
            state_q   <= state_d;
        end
    end

    assign pc_out         = pc_q;
    assign instret        = instret_q;
    assign flush          = flush_q;
    assign halted         = halted_q;
    assign err_misaligned = err_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench: two instances (bypass on / off) share stimulus; a reference model feeds a scoreboard queue.
module tb_writeback_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data1, rs2_data1, pc_out1;
    logic [31:0] rs1_data0, rs2_data0, pc_out0;
    logic        flush1, halted1, err1, flush0, halted0, err0;
    logic [63:0] instret1, instret0;

    writeback_stage_if wb1 ();
    writeback_stage_if wb0 ();

    writeback_stage #(.BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wb(wb1.slave),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data1), .rs2_data(rs2_data1), .pc_out(pc_out1),
        .flush(flush1), .halted(halted1), .err_misaligned(err1), .instret(instret1)
    );

    writeback_stage #(.BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wb(wb0.slave),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data0), .rs2_data(rs2_data0), .pc_out(pc_out0),
        .flush(flush0), .halted(halted0), .err_misaligned(err0), .instret(instret0)
    );

    typedef struct {
        logic [31:0] pc;
        logic [63:0] cnt;
        logic        flush;
        logic        halted;
        logic        err;
        logic        rdy;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [63:0] m_cnt;
    int          m_st;
    logic        m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic we, input logic [31:0] val, input logic redir,
                         input logic [31:0] npc, input logic halt);
        wb1.in_valid = v;  wb0.in_valid = v;
        wb1.in_pc = pc;    wb0.in_pc = pc;
        wb1.in_rd = rd;    wb0.in_rd = rd;
        wb1.in_rd_we = we; wb0.in_rd_we = we;
        wb1.in_rd_value = val; wb0.in_rd_value = val;
        wb1.in_redirect = redir; wb0.in_redirect = redir;
        wb1.in_next_pc = npc; wb0.in_next_pc = npc;
        wb1.in_halt = halt; wb0.in_halt = halt;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc = 32'h0; m_cnt = 64'h0; m_st = 0; m_err = 1'b0;
    endtask

    task automatic rd_chk(input logic [4:0] a);
        logic [31:0] e;
        rs1_addr = a; rs2_addr = a;
        e = (a == 5'd0) ? 32'h0 : m_regs[a];
        #1;
        chk("rd1_rs1", rs1_data1, e);
        chk("rd1_rs2", rs2_data1, e);
        chk("rd0_rs1", rs1_data0, e);
    endtask

    task automatic cycle(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic we, input logic [31:0] val, input logic redir,
                         input logic [31:0] npc, input logic halt);
        logic acc, mis, wr;
        logic [31:0] tgt, old;
        exp_t e;
        @(negedge clk);
        drive(v, pc, rd, we, val, redir, npc, halt);
        rs1_addr = rd; rs2_addr = rd;
        acc = v && (m_st == 0);
        tgt = {npc[31:1], 1'b0};
        mis = redir && tgt[1];
        wr  = acc && !mis && we && (rd != 5'd0);
        old = (rd == 5'd0) ? 32'h0 : m_regs[rd];
        #1;
        chk("in_ready_pre", wb1.in_ready, m_st == 0);
        chk("byp1_rs1", rs1_data1, wr ? val : old);
        chk("byp1_rs2", rs2_data1, wr ? val : old);
        chk("byp0_rs1", rs1_data0, old);
        if (wr) m_regs[rd] = val;
        e.flush = 1'b0;
        if (acc) begin
            if (mis) begin
                m_pc = pc; m_err = 1'b1; e.flush = 1'b1; m_st = 2;
            end else begin
                m_pc = redir ? tgt : pc + 32'd4;
                e.flush = redir;
                m_cnt = m_cnt + 64'd1;
                if (halt) m_st = 1;
            end
        end
        e.pc = m_pc; e.cnt = m_cnt; e.err = m_err;
        e.halted = (m_st != 0); e.rdy = (m_st == 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        wb1.in_valid = 1'b0; wb0.in_valid = 1'b0;
        e = sb.pop_front();
        chk("pc_out", pc_out1, e.pc);
        chk("pc_out_nobyp", pc_out0, e.pc);
        chk("instret", instret1, e.cnt);
        chk("flush", flush1, e.flush);
        chk("halted", halted1, e.halted);
        chk("err_misaligned", err1, e.err);
        chk("in_ready", wb1.in_ready, e.rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_pc", pc_out1, 32'h0);
        chk("rst_instret", instret1, 64'h0);
        chk("rst_halted", halted1, 1'b0);
        chk("rst_flush", flush1, 1'b0);
        chk("rst_err", err1, 1'b0);
        chk("rst_ready", wb1.in_ready, 1'b1);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_pc", pc_out1, 32'h0);
        chk("post_rst_halted", halted1, 1'b0);
        chk("post_rst_ready", wb1.in_ready, 1'b1);
    endtask

    initial begin
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        model_reset();
        do_reset();
        rd_chk(5'd5);

        // Plain write with same-cycle bypass on x5
        cycle(1'b1, 32'h100, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        rd_chk(5'd5);
        // x0 write is discarded
        cycle(1'b1, 32'h104, 5'd0, 1'b1, 32'h1234, 1'b0, 32'h0, 1'b0);
        rd_chk(5'd0);
        // Taken jump with odd target: bit 0 dropped, flush pulses once
        cycle(1'b1, 32'h200, 5'd1, 1'b1, 32'h204, 1'b1, 32'h301, 1'b0);
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rd_chk(5'd1);
        // Back-to-back accepts, overwrite of x5, we=0 leaves register alone, PC wrap
        cycle(1'b1, 32'h300, 5'd5, 1'b1, 32'h0A0A0A0A, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h304, 5'd5, 1'b1, 32'h5555AAAA, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h308, 5'd1, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'hFFFFFFFC, 5'd31, 1'b1, 32'h80000001, 1'b0, 32'h0, 1'b0);
        rd_chk(5'd5);
        rd_chk(5'd1);
        rd_chk(5'd31);
        // Misaligned redirect: fault, no write, no retire; later valids ignored
        cycle(1'b1, 32'h400, 5'd2, 1'b1, 32'h99, 1'b1, 32'h502, 1'b1);
        rd_chk(5'd2);
        cycle(1'b1, 32'h404, 5'd2, 1'b1, 32'h77, 1'b0, 32'h0, 1'b0);
        rd_chk(5'd2);

        do_reset();
        rd_chk(5'd1);
        // Halting instruction still retires, then stage stalls with valid held
        cycle(1'b1, 32'h500, 5'd3, 1'b1, 32'h7, 1'b0, 32'h0, 1'b1);
        rd_chk(5'd3);
        cycle(1'b1, 32'h504, 5'd3, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h504, 5'd3, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
        rd_chk(5'd3);

        do_reset();
        rd_chk(5'd3);
        // Jump flagged halt: redirect PC, flush and HALT together
        cycle(1'b1, 32'h600, 5'd4, 1'b1, 32'h604, 1'b1, 32'h800, 1'b1);
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rd_chk(5'd4);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
